// File: rtl/register_file_8x32_pkg.sv
// Shared constants for the register file, shifter and counter blocks.
package register_file_8x32_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] RESET_VAL = 32'h0000_0000;
endpackage

// File: rtl/_3_to_8_decoder.sv
// One-hot 3-to-8 decoder with enable, built from inverters and 4-input ANDs.
module _3_to_8_decoder (
  input  logic       en_i,
  input  logic [2:0] addr_i,
  output logic [7:0] dec_o
);
  logic [2:0] addr_n;

  for (genvar k = 0; k < 3; k++) begin : g_inv
    _inv u_inv (.a_i(addr_i[k]), .y_o(addr_n[k]));
  end

  // Each output ANDs the enable with the true/complemented address literals matching its index.
  for (genvar i = 0; i < 8; i++) begin : g_dec
    localparam logic [2:0] IDX = 3'(i);
    _and4 u_and (
      .a_i(en_i),
      .b_i(IDX[2] ? addr_i[2] : addr_n[2]),
      .c_i(IDX[1] ? addr_i[1] : addr_n[1]),
      .d_i(IDX[0] ? addr_i[0] : addr_n[0]),
      .y_o(dec_o[i])
    );
  end
endmodule

// File: rtl/_8_to_1_mux_32bits.sv
// 8-to-1, 32-bit AND-OR multiplexer: one-hot select gates each input, then an OR tree merges them.
module _8_to_1_mux_32bits (
  input  logic [7:0][31:0] data_i,
  input  logic [2:0]       sel_i,
  output logic [31:0]      data_o
);
  logic [7:0]       sel_oh;
  logic [7:0][31:0] gated;
  logic [3:0][31:0] lvl1;
  logic [1:0][31:0] lvl2;

  _3_to_8_decoder u_sel_dec (
    .en_i  (1'b1),
    .addr_i(sel_i),
    .dec_o (sel_oh)
  );

  for (genvar i = 0; i < 8; i++) begin : g_gate
    _and32 u_and (.a_i(data_i[i]), .b_i({32{sel_oh[i]}}), .y_o(gated[i]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    _or32 u_or (.a_i(gated[2*i]), .b_i(gated[2*i+1]), .y_o(lvl1[i]));
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    _or32 u_or (.a_i(lvl1[2*i]), .b_i(lvl1[2*i+1]), .y_o(lvl2[i]));
  end

  _or32 u_or_root (.a_i(lvl2[0]), .b_i(lvl2[1]), .y_o(data_o));
endmodule

// File: rtl/_and32.sv
// Gate library: 32-bit bitwise 2-input AND.
module _and32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/_and4.sv
// Gate library: 4-input AND.
module _and4 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic y_o
);
  assign y_o = a_i & b_i & c_i & d_i;
endmodule

// File: rtl/_inv.sv
// Gate library: single-bit inverter.
module _inv (
  input  logic a_i,
  output logic y_o
);
  assign y_o = ~a_i;
endmodule

// File: rtl/_or32.sv
// Gate library: 32-bit bitwise 2-input OR.
module _or32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/_register32_r_en.sv
// 32-bit register with asynchronous active-low clear and synchronous load enable.
module _register32_r_en
  import register_file_8x32_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  assign data_d = en_i ? d_i : data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;
endmodule

// File: rtl/register_file_8x32.sv
// 8x32 register file: one synchronous write port, two independent combinational read ports.
module register_file_8x32
  import register_file_8x32_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [ADDR_WIDTH-1:0] rAddr_a,
  output logic [DATA_WIDTH-1:0] rData_a,
  input  logic [ADDR_WIDTH-1:0] rAddr_b,
  output logic [DATA_WIDTH-1:0] rData_b
);
  logic [DEPTH-1:0]                 wr_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] reg_q;

  _3_to_8_decoder u_wr_dec (
    .en_i  (we),
    .addr_i(wAddr),
    .dec_o (wr_en)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    _register32_r_en u_reg (
      .clk_i (clk),
      .rst_ni(reset_n),
      .en_i  (wr_en[i]),
      .d_i   (wData),
      .q_o   (reg_q[i])
    );
  end

  // Reads are unbypassed: a same-address write shows up only after the edge.
  _8_to_1_mux_32bits u_rd_mux_a (
    .data_i(reg_q),
    .sel_i (rAddr_a),
    .data_o(rData_a)
  );

  _8_to_1_mux_32bits u_rd_mux_b (
    .data_i(reg_q),
    .sel_i (rAddr_b),
    .data_o(rData_b)
  );
endmodule

// File: tb/tb_register_file_8x32.sv
// Directed self-checking bench for register_file_8x32.
module tb_register_file_8x32;
  logic        clk;
  logic        reset_n;
  logic        we;
  logic [2:0]  wAddr;
  logic [31:0] wData;
  logic [2:0]  rAddr_a;
  logic [31:0] rData_a;
  logic [2:0]  rAddr_b;
  logic [31:0] rData_b;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_8x32 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .wAddr  (wAddr),
    .wData  (wData),
    .rAddr_a(rAddr_a),
    .rData_a(rData_a),
    .rAddr_b(rAddr_b),
    .rData_b(rData_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
    we    = 1'b1;
    wAddr = addr;
    wData = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    wAddr   = 3'd0;
    wData   = 32'h0;
    rAddr_a = 3'd0;
    rAddr_b = 3'd7;
    #2;
    check_eq("reset_a", rData_a, 32'h0);
    check_eq("reset_b", rData_b, 32'h0);

    // Release away from any rising edge (rising edges at 5, 15, 25 ...).
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) write_reg(3'(i), 32'hA5A5_0000 + 32'(i));

    for (int i = 0; i < 8; i++) begin
      rAddr_a = 3'(i);
      rAddr_b = 3'(7 - i);
      #1;
      check_eq($sformatf("sweep_a[%0d]", i), rData_a, 32'hA5A5_0000 + 32'(i));
      check_eq($sformatf("sweep_b[%0d]", 7 - i), rData_b, 32'hA5A5_0000 + 32'(7 - i));
    end

    we    = 1'b0;
    wAddr = 3'd3;
    wData = 32'hFFFF_FFFF;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rAddr_a = 3'(i);
      #1;
      check_eq($sformatf("hold[%0d]", i), rData_a, 32'hA5A5_0000 + 32'(i));
    end

    @(negedge clk);
    rAddr_a = 3'd5;
    rAddr_b = 3'd4;
    we      = 1'b1;
    wAddr   = 3'd5;
    wData   = 32'hDEAD_BEEF;
    #1;
    check_eq("rdw_before_a", rData_a, 32'hA5A5_0005);
    check_eq("rdw_before_b", rData_b, 32'hA5A5_0004);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_eq("rdw_after_a", rData_a, 32'hDEAD_BEEF);
    check_eq("rdw_after_b", rData_b, 32'hA5A5_0004);

    rAddr_a = 3'd2;
    rAddr_b = 3'd2;
    #1;
    check_eq("dual_before_a", rData_a, 32'hA5A5_0002);
    check_eq("dual_before_b", rData_b, 32'hA5A5_0002);
    write_reg(3'd2, 32'h1234_5678);
    check_eq("dual_after_a", rData_a, 32'h1234_5678);
    check_eq("dual_after_b", rData_b, 32'h1234_5678);

    // Reset between edges with every entry holding a non-zero value.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      rAddr_a = 3'(i);
      rAddr_b = 3'(7 - i);
      #0.1;
      check_eq($sformatf("async_rst_a[%0d]", i), rData_a, 32'h0);
      check_eq($sformatf("async_rst_b[%0d]", 7 - i), rData_b, 32'h0);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    write_reg(3'd6, 32'h1111_1111);
    write_reg(3'd1, 32'h2222_2222);
    rAddr_a = 3'd6;
    rAddr_b = 3'd1;
    #1;
    check_eq("preload6", rData_a, 32'h1111_1111);
    check_eq("preload1", rData_b, 32'h2222_2222);

    // Reset held low across a rising edge that carries a write.
    @(negedge clk);
    we    = 1'b1;
    wAddr = 3'd6;
    wData = 32'h0F0F_0F0F;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #3;
    we = 1'b0;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      rAddr_a = 3'(i);
      #1;
      check_eq($sformatf("rst_mid_write[%0d]", i), rData_a, 32'h0);
    end

    @(negedge clk);
    write_reg(3'd6, 32'h0F0F_0F0F);
    rAddr_a = 3'd6;
    rAddr_b = 3'd5;
    #1;
    check_eq("post_rst_write6", rData_a, 32'h0F0F_0F0F);
    check_eq("post_rst_keep5", rData_b, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
